// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite response codes, status bit positions and FSM state type
//
// Purpose: types and constants shared by the AXI-Lite FIFO peripherals.
// Contents: resp_t and RSP_* codes, STATUS_* bit positions, rd_state_t.
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RSP_OKAY   = 2'b00;
  localparam resp_t RSP_EXOKAY = 2'b01;
  localparam resp_t RSP_SLVERR = 2'b10;
  localparam resp_t RSP_DECERR = 2'b11;

  // Status register layout: count in the low half-word, flags above it.
  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_EMPTY_BIT = 16;
  localparam int STATUS_FULL_BIT  = 17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi_lite_read_fifo_if.sv
// rtl/axi_lite_read_fifo_if.sv - producer stream plus AXI-Lite read channel bundle
//
// Purpose: groups the producer stream and the AXI-Lite AR/R channels.
// Signals: valid_in/ready_in/data_in (producer), s_axi_ar* (read address),
//          s_axi_r* (read data). slave = the FIFO bridge, master = its peers.
interface axi_lite_read_fifo_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 32
);
  import axi_lite_pkg::*;

  logic                  valid_in;
  logic                  ready_in;
  logic [BUS_WIDTH-1:0]  data_in;
  logic                  s_axi_arready;
  logic                  s_axi_arvalid;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic [2:0]            s_axi_arprot;
  logic                  s_axi_rready;
  logic                  s_axi_rvalid;
  logic [BUS_WIDTH-1:0]  s_axi_rdata;
  resp_t                 s_axi_rresp;

  modport slave (
    input  valid_in, data_in, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
    output ready_in, s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

  modport master (
    output valid_in, data_in, s_axi_arvalid, s_axi_araddr, s_axi_arprot, s_axi_rready,
    input  ready_in, s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: storage, wrapping pointers and count for the read bridge.
// Ports: clk, reset (async, active-high), push_i, pop_i, wdata_i,
//        rdata_o (head word), full_o, empty_o, count_o.
// Callers must gate push_i with ~full_o and pop_i with ~empty_o.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int ADDR_SIZE = $clog2(DEPTH);
  localparam int CW        = $clog2(DEPTH+1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/axi_lite_read_fifo.sv
// rtl/axi_lite_read_fifo.sv - stream-to-AXI-Lite bridge draining a FIFO through a data register
//
// Purpose: producer words enter a FIFO; each accepted AXI-Lite read of ADDRESS pops one.
// Ports: clk, reset (async, active-high), bus (axi_lite_read_fifo_if.slave).
// Option: AXI_LITE_READ_FIFO_STATUS_EN maps a read-only status word at ADDRESS+BUS_WIDTH/8.
module axi_lite_read_fifo
  import axi_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    BUS_WIDTH  = 32,
  parameter int                    DEPTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDRESS    = '0
) (
  input logic                 clk,
  input logic                 reset,
  axi_lite_read_fifo_if.slave bus
);
  localparam int ALIGN = $clog2(BUS_WIDTH/8);
  localparam int CW    = $clog2(DEPTH+1);

  rd_state_t            state_q, state_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  resp_t                rresp_q, rresp_d;

  logic                 fifo_full, fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [BUS_WIDTH-1:0] fifo_head;
  logic [BUS_WIDTH-1:0] status_word;
  logic                 push, pop, arready_c, ar_hs, hit_data, hit_status;
  logic                 unused;

  // ready_in depends only on FIFO state, never on the AXI side.
  assign bus.ready_in = ~fifo_full;
  assign push         = bus.valid_in & ~fifo_full;
  assign hit_data     = (bus.s_axi_araddr[ADDR_WIDTH-1:ALIGN] == ADDRESS[ADDR_WIDTH-1:ALIGN]);

`ifdef AXI_LITE_READ_FIFO_STATUS_EN
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(ADDRESS + ADDR_WIDTH'(BUS_WIDTH/8));
  assign hit_status = (bus.s_axi_araddr[ADDR_WIDTH-1:ALIGN] == STATUS_ADDR[ADDR_WIDTH-1:ALIGN]);
  always_comb begin
    status_word = '0;
    status_word[STATUS_COUNT_LSB +: CW] = fifo_count;
    status_word[STATUS_EMPTY_BIT]       = fifo_empty;
    status_word[STATUS_FULL_BIT]        = fifo_full;
  end
  assign unused = ^{1'b0, bus.s_axi_arprot, bus.s_axi_araddr[ALIGN-1:0]};
`else
  assign hit_status  = 1'b0;
  assign status_word = '0;
  assign unused = ^{1'b0, bus.s_axi_arprot, bus.s_axi_araddr[ALIGN-1:0], fifo_count};
`endif

  sync_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (bus.data_in),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready_c = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: arready_c = 1'b1;
      ST_RESP: begin
        // Accepting a new address exactly when the current beat retires keeps one read per cycle.
        arready_c = bus.s_axi_rready;
        if (bus.s_axi_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ar_hs = bus.s_axi_arvalid & arready_c;
    if (ar_hs) begin
      state_d = ST_RESP;
      if (hit_data) begin
        if (!fifo_empty) begin
          rdata_d = fifo_head;
          rresp_d = RSP_OKAY;
          pop     = 1'b1;
        end else begin
          rdata_d = '0;
          rresp_d = RSP_SLVERR;
        end
      end else if (hit_status) begin
        rdata_d = status_word;
        rresp_d = RSP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RSP_DECERR;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      rresp_q <= RSP_OKAY;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign bus.s_axi_arready = arready_c;
  assign bus.s_axi_rvalid  = (state_q == ST_RESP);
  assign bus.s_axi_rdata   = rdata_q;
  assign bus.s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_read_fifo.sv
// tb/tb_axi_lite_read_fifo.sv - self-checking bench for axi_lite_read_fifo
module tb_axi_lite_read_fifo;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_lite_read_fifo_if #(.ADDR_WIDTH(32), .BUS_WIDTH(32)) bus ();

  axi_lite_read_fifo #(
    .ADDR_WIDTH (32),
    .BUS_WIDTH  (32),
    .DEPTH      (8),
    .ADDRESS    (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          do_push;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    int n = 0;
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    while (!bus.ready_in && n < 20) begin
      step();
      n++;
    end
    check("push_ready", {31'b0, bus.ready_in}, 32'd1);
    step();
    bus.valid_in = 1'b0;
  endtask

  task automatic read_once(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr  = addr;
    bus.s_axi_rready  = 1'b1;
    check("arready_idle", {31'b0, bus.s_axi_arready}, 32'd1);
    step();
    bus.s_axi_arvalid = 1'b0;
    check("rvalid_beat", {31'b0, bus.s_axi_rvalid}, 32'd1);
    d = bus.s_axi_rdata;
    r = bus.s_axi_rresp;
    step();
    check("rvalid_done", {31'b0, bus.s_axi_rvalid}, 32'd0);
  endtask

  task automatic read_expect(input string name, input logic [31:0] addr,
                             input logic [31:0] ed, input logic [1:0] er);
    logic [31:0] d;
    logic [1:0]  r;
    read_once(addr, d, r);
    check({name, "_data"}, d, ed);
    check({name, "_resp"}, {30'b0, r}, {30'b0, er});
  endtask

  function automatic logic [31:0] cnt();
    return {28'b0, dut.u_fifo.count_q};
  endfunction

  initial begin
    vecs[0] = '{1'b0, 32'h0,  32'h000, 32'h0,  RSP_SLVERR, 4'd0};
    vecs[1] = '{1'b1, 32'h55, 32'h000, 32'h55, RSP_OKAY,   4'd0};
    vecs[2] = '{1'b1, 32'h11, 32'h100, 32'h0,  RSP_DECERR, 4'd1};
`ifdef AXI_LITE_READ_FIFO_STATUS_EN
    vecs[3] = '{1'b0, 32'h0,  32'h004, 32'h0000_0001, RSP_OKAY, 4'd1};
`else
    vecs[3] = '{1'b0, 32'h0,  32'h004, 32'h0,  RSP_DECERR, 4'd1};
`endif
    vecs[4] = '{1'b0, 32'h0,  32'h000, 32'h11, RSP_OKAY,   4'd0};
`ifdef AXI_LITE_READ_FIFO_STATUS_EN
    vecs[5] = '{1'b0, 32'h0,  32'h004, 32'h0001_0000, RSP_OKAY, 4'd0};
`else
    vecs[5] = '{1'b0, 32'h0,  32'h004, 32'h0,  RSP_DECERR, 4'd0};
`endif
    vecs[6] = '{1'b1, 32'h66, 32'h008, 32'h0,  RSP_DECERR, 4'd1};
    vecs[7] = '{1'b0, 32'h0,  32'h003, 32'h66, RSP_OKAY,   4'd0};

    reset = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_araddr = '0;
    bus.s_axi_arprot = 3'b000;
    bus.s_axi_rready = 1'b0;
    step();
    step();
    check("rst_arready", {31'b0, bus.s_axi_arready}, 32'd1);
    check("rst_rvalid",  {31'b0, bus.s_axi_rvalid}, 32'd0);
    check("rst_rdata",   bus.s_axi_rdata, 32'd0);
    check("rst_rresp",   {30'b0, bus.s_axi_rresp}, 32'd0);
    check("rst_ready_in", {31'b0, bus.ready_in}, 32'd1);
    check("rst_count",   cnt(), 32'd0);
    reset = 1'b0;
    step();

    // Back-to-back reads, one beat per cycle.
    push_word(32'hA1);
    push_word(32'hB2);
    push_word(32'hC3);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr  = 32'h0;
    bus.s_axi_rready  = 1'b1;
    step();
    check("b2b_0_data", bus.s_axi_rdata, 32'hA1);
    check("b2b_0_arready", {31'b0, bus.s_axi_arready}, 32'd1);
    step();
    check("b2b_1_data", bus.s_axi_rdata, 32'hB2);
    step();
    check("b2b_2_data", bus.s_axi_rdata, 32'hC3);
    check("b2b_2_resp", {30'b0, bus.s_axi_rresp}, 32'd0);
    check("b2b_2_valid", {31'b0, bus.s_axi_rvalid}, 32'd1);
    bus.s_axi_arvalid = 1'b0;
    step();
    check("b2b_idle", {31'b0, bus.s_axi_rvalid}, 32'd0);
    check("b2b_count", cnt(), 32'd0);

    // Single-read vectors.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_push) push_word(vecs[i].wdata);
      read_expect($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_data, vecs[i].exp_resp);
      check($sformatf("vec%0d_count", i), cnt(), {28'b0, vecs[i].exp_count});
    end

    // Empty FIFO: push and data read in the same cycle.
    bus.valid_in = 1'b1;
    bus.data_in = 32'h5A;
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr = 32'h0;
    bus.s_axi_rready = 1'b1;
    step();
    bus.valid_in = 1'b0;
    bus.s_axi_arvalid = 1'b0;
    check("same_resp", {30'b0, bus.s_axi_rresp}, {30'b0, RSP_SLVERR});
    check("same_data", bus.s_axi_rdata, 32'h0);
    check("same_count", cnt(), 32'd1);
    step();
    read_expect("same_after", 32'h0, 32'h5A, RSP_OKAY);

    // Fill, hold a ninth push until a pop, then drain through the wrap.
    for (int i = 0; i < 8; i++) push_word(32'h100 + i);
    check("full_ready_in", {31'b0, bus.ready_in}, 32'd0);
    check("full_count", cnt(), 32'd8);
    bus.valid_in = 1'b1;
    bus.data_in = 32'h99;
    step();
    check("held_ready_in", {31'b0, bus.ready_in}, 32'd0);
    check("held_count", cnt(), 32'd8);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr = 32'h0;
    bus.s_axi_rready = 1'b1;
    step();
    bus.s_axi_arvalid = 1'b0;
    check("wrap_first", bus.s_axi_rdata, 32'h100);
    check("wrap_count7", cnt(), 32'd7);
    check("wrap_ready_in", {31'b0, bus.ready_in}, 32'd1);
    step();
    bus.valid_in = 1'b0;
    check("wrap_count8", cnt(), 32'd8);
    for (int i = 1; i < 8; i++) read_expect($sformatf("wrap%0d", i), 32'h0, 32'h100 + i, RSP_OKAY);
    read_expect("wrap_ninth", 32'h0, 32'h99, RSP_OKAY);
    check("wrap_empty", cnt(), 32'd0);

    // Backpressure on R for five cycles.
    push_word(32'h77);
    push_word(32'h88);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr = 32'h0;
    bus.s_axi_rready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d_valid", k), {31'b0, bus.s_axi_rvalid}, 32'd1);
      check($sformatf("hold%0d_data", k), bus.s_axi_rdata, 32'h77);
      check($sformatf("hold%0d_resp", k), {30'b0, bus.s_axi_rresp}, 32'd0);
      check($sformatf("hold%0d_arready", k), {31'b0, bus.s_axi_arready}, 32'd0);
      check($sformatf("hold%0d_count", k), cnt(), 32'd1);
      step();
    end
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b1;
    step();
    check("hold_release", {31'b0, bus.s_axi_rvalid}, 32'd0);
    check("hold_count", cnt(), 32'd1);
    read_expect("hold_next", 32'h0, 32'h88, RSP_OKAY);

    // Status address with three words queued.
    push_word(32'h31);
    push_word(32'h32);
    push_word(32'h33);
`ifdef AXI_LITE_READ_FIFO_STATUS_EN
    read_expect("status3", 32'h4, 32'h0000_0003, RSP_OKAY);
`else
    read_expect("status3", 32'h4, 32'h0, RSP_DECERR);
`endif
    check("status3_count", cnt(), 32'd3);
    read_expect("drain0", 32'h0, 32'h31, RSP_OKAY);
    read_expect("drain1", 32'h0, 32'h32, RSP_OKAY);
    read_expect("drain2", 32'h0, 32'h33, RSP_OKAY);

    // Reset in the middle of a pending R beat.
    push_word(32'hE1);
    push_word(32'hE2);
    bus.s_axi_arvalid = 1'b1;
    bus.s_axi_araddr = 32'h0;
    bus.s_axi_rready = 1'b0;
    step();
    check("mid_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    bus.s_axi_arvalid = 1'b0;
    check("mid_rst_rvalid", {31'b0, bus.s_axi_rvalid}, 32'd0);
    check("mid_rst_arready", {31'b0, bus.s_axi_arready}, 32'd1);
    check("mid_rst_rdata", bus.s_axi_rdata, 32'd0);
    check("mid_rst_count", cnt(), 32'd0);
    check("mid_rst_ready_in", {31'b0, bus.ready_in}, 32'd1);
    step();
    reset = 1'b0;
    step();
    read_expect("mid_after", 32'h0, 32'h0, RSP_SLVERR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_read_fifo.md
# axi_lite_read_fifo

Stream-to-AXI-Lite bridge: a producer pushes words into an internal FIFO through a valid/ready stream port, and an AXI-Lite master drains them by reading a fixed data-register address. Each accepted read of the data address pops one word. This block is the read-side counterpart of the write-FIFO slave and sits on the same AXI-Lite peripheral bus, e.g. as an RX mailbox or event queue.

## Interface
- ADDRESS, 'h0000_0000: byte address of the data register; must be BUS_WIDTH/8 aligned.
- ADDR_WIDTH, 32: AXI address width.
- BUS_WIDTH, 32: data width; must be 32 or 64.
- DEPTH, 8: FIFO entries; power of 2, at least 2.
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- valid_in  in  1  producer word valid.
- ready_in  out  1  FIFO not full.
- data_in  in  BUS_WIDTH  producer word.
- s_axi_arready  out  1  read-address ready.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_rready  in  1  read-data ready.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rdata  out  BUS_WIDTH  read data.
- s_axi_rresp  out  2  response: OKAY=00, SLVERR=10, DECERR=11.

## Operation
- FIFO:
  - Pointers are ADDR_SIZE=$clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH+1) bits; full = (count==DEPTH), so all DEPTH entries are usable.
  - ready_in = ~full, registered-state only, with no path from AXI inputs.
  - push = valid_in & ready_in.
  - When full, a same-cycle pop does not enable a push.
- Address decode compares araddr[ADDR_WIDTH-1:ALIGN] with ADDRESS>>ALIGN, where ALIGN = $clog2(BUS_WIDTH/8).
- FSM states:
  - IDLE: arready=1, rvalid=0. On the AR handshake, load the response registers and go to RESP.
  - RESP: rvalid=1; rdata/rresp held stable; arready = rready.
    - rready & arvalid: load the next response and stay in RESP (back-to-back).
    - rready & ~arvalid: go to IDLE.
    - ~rready: stay in RESP.
- Response loaded on the AR handshake:
  - Data address, FIFO non-empty: rdata = head word, rresp = OKAY, pop.
  - Data address, FIFO empty: rdata = 0, rresp = SLVERR, no pop.
  - Status address (see Configuration): status word, OKAY, no pop.
  - Any other address: rdata = 0, rresp = DECERR, no pop.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Empty FIFO with a push and a data read in the same cycle: the read returns SLVERR and the pushed word is retained (count becomes 1).

## Timing
- AR handshake in cycle N gives rvalid=1 in cycle N+1 with final rdata/rresp.
- Sustained throughput is one read per cycle while rready=1.
- A word pushed in cycle N is visible to a read whose AR handshake is in cycle N+1 or later.
- Reset, from assertion to release:
  - State IDLE; pointers and count 0.
  - s_axi_arready=1, s_axi_rvalid=0, s_axi_rdata=0, s_axi_rresp=00, ready_in=1.
  - FIFO storage is not reset.
- Reset asserted mid-transaction: a pending R beat is dropped and FIFO contents are discarded.

## Configuration
- AXI_LITE_READ_FIFO_STATUS_EN defined: address ADDRESS+BUS_WIDTH/8 is a read-only status register, returned with OKAY and no pop.
  - Bits [15:0] = count, zero-extended.
  - Bit [16] = empty.
  - Bit [17] = full.
  - All other bits 0.
- Undefined: that address decodes as any other address (DECERR, rdata=0).

## Structure
- Shared package axi_lite_pkg holds:
  - The resp_t typedef and the RSP_OKAY/RSP_EXOKAY/RSP_SLVERR/RSP_DECERR constants (same values as the write-FIFO slave).
  - The STATUS_*_BIT bit-position constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) holds storage, pointers and count, and exposes full/empty/count.
- The top level contains only address decode, the FSM and the response registers.

## Test plan
- Reset, then push 0xA1, 0xB2, 0xC3; read ADDRESS three times with rready=1 -> rdata A1, B2, C3 with OKAY on consecutive cycles; count ends at 0.
- Read ADDRESS with the FIFO empty -> rdata=0, rresp=SLVERR; a subsequent push of 0x55 and read -> 0x55 with OKAY.
- Push DEPTH=8 words -> ready_in=0 after the 8th. A 9th push is held until one read pops, then accepted; all 9 words are read back in order, exercising pointer wrap.
- Hold rready=0 for 5 cycles after the AR handshake -> rvalid stays 1, rdata/rresp are stable, arready=0, and exactly one pop occurs.
- Read ADDRESS+'h100 -> DECERR, rdata=0, count unchanged.
- With AXI_LITE_READ_FIFO_STATUS_EN and 3 words queued, read ADDRESS+4 -> rdata=0x0000_0003, OKAY, no pop. Without the macro, the same read -> DECERR.
